// File: rtl/mux_arb_pkg.sv
// Shared types and the rotating-priority pick function for mux-tree controllers.
// MUX_ARB_LOCK_EN is consumed by mux_rr_arbiter, not by this package.
package mux_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int unsigned MAX_N = 16;

  // First set bit of valid scanning ptr+1, ptr+2, ... modulo n; 0 when none is set.
  function automatic logic [3:0] rr_pick(input logic [MAX_N-1:0] valid,
                                         input logic [3:0]       ptr,
                                         input int unsigned      n);
    logic [3:0] idx;
    logic       found;
    rr_pick = '0;
    found   = 1'b0;
    for (int unsigned k = 1; k <= MAX_N; k++) begin
      idx = 4'((32'(ptr) + k) % n);
      if (k <= n && !found && valid[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/mux_arb_rr_pick.sv
// Combinational round-robin pick: rotate priority past ptr and encode the winner.
// Reusable by any mux-tree controller that owns an SW-bit select code.
module mux_arb_rr_pick
  import mux_arb_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned SW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] idx,
  output logic          any
);

  logic [MAX_N-1:0] valid_ext;
  logic [3:0]       ptr_ext;

  always_comb begin
    valid_ext         = '0;
    valid_ext[N-1:0]  = valid;
    ptr_ext           = '0;
    ptr_ext[SW-1:0]   = ptr;
  end

  assign idx = SW'(rr_pick(valid_ext, ptr_ext, N));
  assign any = |valid;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the mux_tree select code and a registered output beat.
// Optional packet lock via `define MUX_ARB_LOCK_EN (grant held until a last beat).
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter  int unsigned N  = 4,
  parameter  int unsigned W  = 8,
  localparam int unsigned SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_last,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  input  logic           out_ready,
  output logic [SW-1:0]  out_sel,
  output logic           busy
);

  state_e        state_q, state_d;
  logic [SW-1:0] rr_ptr_q, rr_ptr_d;
  logic [SW-1:0] out_sel_q, out_sel_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_last_q, out_last_d;

  logic [SW-1:0] pick_idx;
  logic          pick_any;
  logic [W-1:0]  sel_data;
  logic          sel_ready;
  logic          accept;
  logic          rel;

  mux_arb_rr_pick #(.N(N)) u_pick (
    .valid (in_valid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign sel_data = in_data[out_sel_q*W +: W];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    in_ready    = '0;
    sel_ready   = 1'b0;
    accept      = 1'b0;
    rel         = 1'b0;

    // Draining applies in IDLE too, so a final beat left after release still empties.
    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          out_sel_d = pick_idx;
          state_d   = GRANT;
        end
      end
      GRANT: begin
        sel_ready           = !out_valid_q || out_ready;
        in_ready[out_sel_q] = sel_ready;
        accept              = in_valid[out_sel_q] && sel_ready;
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = sel_data;
          out_last_d  = in_last[out_sel_q];
        end
`ifdef MUX_ARB_LOCK_EN
        rel = accept && in_last[out_sel_q];
`else
        rel = accept;
`endif
        if (rel) begin
          rr_ptr_d = out_sel_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= SW'(N - 1);
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;
  assign busy      = (state_q == GRANT);

endmodule
